// File: rtl/dev_command_pkg.sv
// Shared definitions for the device command bus.
// Header byte layout is {len[2:0], cmd[4:0]}; len counts the data bytes that follow.
// The command code list is the single source used by every device on the bus.
package dev_command_pkg;

  localparam int unsigned CMD_W = 5;
  localparam int unsigned LEN_W = 3;

  typedef enum logic [CMD_W-1:0] {
    LA_CLEAR    = 5'h0,
    LA_READ_ALL = 5'h1
  } dev_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT_BUSY
  } dev_cmd_sm_e;

  function automatic logic [CMD_W-1:0] hdr_cmd(input logic [7:0] hdr);
    return hdr[CMD_W-1:0];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[CMD_W +: LEN_W];
  endfunction

endpackage

// File: rtl/dev_command_decoder_if.sv
// Device command bus between the UART RX framer and the devices.
//   slave  : decoder side (takes UART bytes and dev_busy, drives command outputs)
//   master : environment side (drives UART bytes and dev_busy, observes command outputs)
interface dev_command_decoder_if;
  import dev_command_pkg::*;

  logic             uart_rx_byte_ready;
  logic [7:0]       uart_rx_byte;
  logic             dev_busy;
  logic             dev_command_started;
  logic             dev_command_processing;
  logic [CMD_W-1:0] dev_command;
  logic             dev_command_data_signal;
  logic [7:0]       dev_data;
  logic             cmd_error;
  logic             cmd_timeout;

  modport slave (
    input  uart_rx_byte_ready, uart_rx_byte, dev_busy,
    output dev_command_started, dev_command_processing, dev_command,
           dev_command_data_signal, dev_data, cmd_error, cmd_timeout
  );

  modport master (
    output uart_rx_byte_ready, uart_rx_byte, dev_busy,
    input  dev_command_started, dev_command_processing, dev_command,
           dev_command_data_signal, dev_data, cmd_error, cmd_timeout
  );

endinterface

// File: rtl/dev_command_decoder.sv
// Frames the UART RX byte stream into device commands (header + 0..7 data bytes).
// Ports:
//   clock, reset : single clock domain, asynchronous active-high reset
//   bus          : command bus (slave side), see dev_command_decoder_if
// All outputs are registered; each strobe appears one cycle after the byte strobe.
// A partial command is aborted after TIMEOUT_CYCLES quiet cycles between bytes.
module dev_command_decoder
  import dev_command_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  dev_command_decoder_if.slave bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

  dev_cmd_sm_e      state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             guard_q, guard_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             started_q, started_d;
  logic             processing_q, processing_d;
  logic [CMD_W-1:0] command_q, command_d;
  logic             data_signal_q, data_signal_d;
  logic [7:0]       data_q, data_d;
  logic             error_q, error_d;
  logic             timeout_q, timeout_d;
  logic             take_header;

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    guard_d       = 1'b0;
    tmo_cnt_d     = '0;
    started_d     = 1'b0;
    processing_d  = processing_q;
    command_d     = command_q;
    data_signal_d = 1'b0;
    data_d        = data_q;
    error_d       = 1'b0;
    timeout_d     = 1'b0;
    take_header   = 1'b0;

    unique case (state_q)
      IDLE: begin
        take_header = bus.uart_rx_byte_ready;
      end
      DATA: begin
        if (bus.uart_rx_byte_ready) begin
          data_d        = bus.uart_rx_byte;
          data_signal_d = 1'b1;
          rem_d         = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = WAIT_BUSY;
            guard_d = 1'b1;
          end
        end else begin
          // Saturating count of quiet cycles since the last byte of this command.
          tmo_cnt_d = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TmoMax) begin
            timeout_d    = 1'b1;
            processing_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      WAIT_BUSY: begin
        // guard_q marks the first cycle, where a device's registered busy may not be up yet.
        if (bus.uart_rx_byte_ready) begin
          if (guard_q || bus.dev_busy) begin
            error_d = 1'b1;
          end else begin
            take_header = 1'b1;
          end
        end else if (!guard_q && !bus.dev_busy) begin
          processing_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Header acceptance is shared by IDLE and a back-to-back header in WAIT_BUSY.
    if (take_header) begin
      command_d    = hdr_cmd(bus.uart_rx_byte);
      rem_d        = hdr_len(bus.uart_rx_byte);
      started_d    = 1'b1;
      processing_d = 1'b1;
      if (hdr_len(bus.uart_rx_byte) != '0) begin
        state_d = DATA;
      end else begin
        state_d = WAIT_BUSY;
        guard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      guard_q       <= 1'b0;
      started_q     <= 1'b0;
      processing_q  <= 1'b0;
      command_q     <= '0;
      data_signal_q <= 1'b0;
      data_q        <= '0;
      error_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      guard_q       <= guard_d;
      started_q     <= started_d;
      processing_q  <= processing_d;
      command_q     <= command_d;
      data_signal_q <= data_signal_d;
      data_q        <= data_d;
      error_q       <= error_d;
      timeout_q     <= timeout_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign bus.dev_command_started     = started_q;
  assign bus.dev_command_processing  = processing_q;
  assign bus.dev_command             = command_q;
  assign bus.dev_command_data_signal = data_signal_q;
  assign bus.dev_data                = data_q;
  assign bus.cmd_error               = error_q;
  assign bus.cmd_timeout             = timeout_q;

endmodule

// File: tb/tb_dev_command_decoder.sv
module tb_dev_command_decoder;

  localparam int unsigned TMO = 16;

  localparam int EvStart = 0;
  localparam int EvData  = 1;
  localparam int EvErr   = 2;
  localparam int EvTmo   = 3;
  localparam int EvDone  = 4;

  typedef struct {
    int         kind;
    int         cyc;
    logic [4:0] cmd;
    logic [7:0] data;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   prev_proc = 1'b0;
  ev_t  exp_q[$];

  // Reference model: command progress tracked as edge times, not machine states.
  bit         m_active = 1'b0;
  int         m_need = 0;
  int         m_last = 0;
  int         m_done = 0;
  logic [4:0] m_cmd = '0;

  dev_command_decoder_if bus_if ();

  dev_command_decoder #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      EvStart: return "started";
      EvData:  return "data";
      EvErr:   return "error";
      EvTmo:   return "timeout";
      default: return "done";
    endcase
  endfunction

  function automatic void push(input int k, input int n, input logic [4:0] c, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = n;
    e.cmd  = c;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void accept(input logic [7:0] b, input int n);
    m_cmd    = b[4:0];
    m_need   = int'(b[7:5]);
    m_active = 1'b1;
    m_last   = n;
    if (m_need == 0) m_done = n;
    push(EvStart, n, m_cmd, 8'h00);
  endfunction

  // n is the index of the clock edge that will sample these inputs.
  function automatic void model(input bit s, input logic [7:0] b, input bit bz, input int n);
    bit guard;
    if (!m_active) begin
      if (s) accept(b, n);
    end else if (m_need > 0) begin
      if (s) begin
        push(EvData, n, m_cmd, b);
        m_need--;
        m_last = n;
        if (m_need == 0) m_done = n;
      end else if (n - m_last == int'(TMO)) begin
        push(EvTmo, n, m_cmd, 8'h00);
        m_active = 1'b0;
      end
    end else begin
      guard = (n == m_done + 1);
      if (s) begin
        if (guard || bz) push(EvErr, n, m_cmd, 8'h00);
        else accept(b, n);
      end else if (!guard && !bz) begin
        push(EvDone, n, m_cmd, 8'h00);
        m_active = 1'b0;
      end
    end
  endfunction

  // Called at a negedge; returns at the next negedge.
  task automatic drive(input bit s, input logic [7:0] b, input bit bz);
    bus_if.uart_rx_byte_ready = s;
    bus_if.uart_rx_byte       = b;
    bus_if.dev_busy           = bz;
    model(s, b, bz, cyc + 1);
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit bz);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, bz);
  endtask

  task automatic check_zero(input string tag);
    logic [24:0] outs;
    outs = {bus_if.dev_command_started, bus_if.dev_command_processing, bus_if.dev_command,
            bus_if.dev_command_data_signal, bus_if.dev_data, bus_if.cmd_error,
            bus_if.cmd_timeout, 2'b00};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, expected all zero", tag, outs);
    end
  endtask

  task automatic check_ev(input int k);
    ev_t e;
    bit  ok;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s cyc=%0d: got event, expected none", ev_name(k), cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc);
    case (k)
      EvStart: ok &= (bus_if.dev_command === e.cmd) && (bus_if.dev_command_processing === 1'b1);
      EvData:  ok &= (bus_if.dev_data === e.data) && (bus_if.dev_command_processing === 1'b1);
      EvErr:   ok &= (bus_if.dev_command_processing === 1'b1);
      EvTmo:   ok &= (bus_if.dev_command_processing === 1'b0);
      default: ok &= (bus_if.dev_command === e.cmd);
    endcase
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s cyc=%0d cmd=%h data=%h proc=%b, expected %s cyc=%0d cmd=%h data=%h",
               ev_name(e.kind), ev_name(k), cyc, bus_if.dev_command, bus_if.dev_data,
               bus_if.dev_command_processing, ev_name(e.kind), e.cyc, e.cmd, e.data);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows an event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (reset || !mon_en) begin
        prev_proc = 1'b0;
      end else begin
        if (bus_if.dev_command_started === 1'b1) check_ev(EvStart);
        if (bus_if.dev_command_data_signal === 1'b1) check_ev(EvData);
        if (bus_if.cmd_error === 1'b1) check_ev(EvErr);
        if (bus_if.cmd_timeout === 1'b1) check_ev(EvTmo);
        if (prev_proc && bus_if.dev_command_processing === 1'b0 && bus_if.cmd_timeout !== 1'b1)
          check_ev(EvDone);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_%s: got nothing at cyc=%0d, expected event at cyc=%0d cmd=%h data=%h",
                   ev_name(e.kind), cyc, e.cyc, e.cmd, e.data);
        end
        prev_proc = (bus_if.dev_command_processing === 1'b1);
      end
    end
  end

  initial begin
    bit   bz;
    bit   s;
    logic [7:0] b;
    bus_if.uart_rx_byte_ready = 1'b0;
    bus_if.uart_rx_byte       = 8'h00;
    bus_if.dev_busy           = 1'b0;
    #3;
    check_zero("reset_values");
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Zero-length command, no busy.
    drive(1'b1, 8'h01, 1'b0);
    idle(4, 1'b0);

    // Two data bytes with a gap between them.
    drive(1'b1, 8'h42, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    idle(3, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    idle(4, 1'b0);

    // Inter-byte timeout, then a fresh header.
    drive(1'b1, 8'h20, 1'b0);
    idle(TMO + 3, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    idle(4, 1'b0);

    // Long busy with a header dropped mid-busy.
    drive(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 100; i++) drive(i == 50, 8'h05, 1'b1);
    idle(3, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    idle(4, 1'b0);

    // Byte in the guard cycle is dropped; header on first non-busy cycle is taken without a gap.
    drive(1'b1, 8'h01, 1'b1);
    drive(1'b1, 8'h07, 1'b0);
    idle(3, 1'b1);
    drive(1'b1, 8'h03, 1'b0);
    idle(4, 1'b0);

    // Reset in the middle of a 7-byte command.
    drive(1'b1, 8'hE3, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    bus_if.uart_rx_byte_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    m_active = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 8'h01, 1'b0);
    idle(4, 1'b0);

    // Randomised traffic with sticky busy and occasional long gaps.
    bz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) bz = ~bz;
      if ($urandom_range(0, 59) == 0) idle(TMO + 2, bz);
      s = ($urandom_range(0, 2) == 0);
      b = 8'($urandom);
      drive(s, b, bz);
    end

    idle(TMO + 10, 1'b0);
    checks++;
    if (exp_q.size() != 0 || bus_if.dev_command_processing !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d proc=%b, expected pending=0 proc=0",
               exp_q.size(), bus_if.dev_command_processing);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
